// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared widths and the queue entry type for the register-file write-back
//   front end (regfile_writeback and its queue, wb_fifo).
//
//   AW     register address width
//   DW     register data width
//   NREGS  number of architectural registers (width of busy_mask)
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NREGS = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

  // Register 0 is hard-wired, so a write to it has no architectural effect.
  function automatic logic is_real_write(input logic [AW-1:0] addr);
    return addr != '0;
  endfunction

endpackage : regfile_pkg

// File: rtl/regfile_writeback_wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
//   In-order circular queue of write-back entries: up to two pushes and one
//   pop per cycle. Push 0 is always the older of two same-cycle pushes.
//   DEPTH must be a power of two so the pointers wrap naturally.
//
//   clk, rst_n       clock, asynchronous active-low reset
//   push0_valid_i    first (older) push strobe
//   push0_entry_i    first push entry
//   push1_valid_i    second (younger) push strobe
//   push1_entry_i    second push entry
//   pop_i            remove the head entry (ignored when empty)
//   count_o          occupied entries
//   view_valid_o     age-ordered valid bits, index 0 = head (oldest)
//   view_entry_o     age-ordered entries, index 0 = head (oldest)
// ---------------------------------------------------------------------------
module wb_fifo
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push0_valid_i,
  input  wb_entry_t               push0_entry_i,
  input  logic                    push1_valid_i,
  input  wb_entry_t               push1_entry_i,
  input  logic                    pop_i,
  output logic [CW-1:0]           count_o,
  output logic [DEPTH-1:0]        view_valid_o,
  output wb_entry_t [DEPTH-1:0]   view_entry_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_p1;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    n_push;
  logic          pop_fire;

  wb_entry_t     mem_q [DEPTH];

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    n_push    = {1'b0, push0_valid_i} + {1'b0, push1_valid_i};
    pop_fire  = pop_i && (count_q != '0);
    wr_ptr_p1 = wr_ptr_q + PW'(1);
    wr_ptr_d  = wr_ptr_q + PW'(n_push);
    rd_ptr_d  = rd_ptr_q + PW'(pop_fire);
    count_d   = count_q + CW'(n_push) - CW'(pop_fire);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count already mark
  // every slot invalid, so clearing the data would only add reset fanout.
  always_ff @(posedge clk) begin
    if (push0_valid_i) begin
      mem_q[wr_ptr_q] <= push0_entry_i;
    end
    // A lone push 1 takes the tail slot; otherwise it lands behind push 0.
    if (push1_valid_i) begin
      mem_q[push0_valid_i ? wr_ptr_p1 : wr_ptr_q] <= push1_entry_i;
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      view_entry_o[k] = mem_q[rd_ptr_q + PW'(k)];
      view_valid_o[k] = CW'(k) < count_q;
    end
  end

  assign count_o = count_q;

endmodule : wb_fifo

// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
//   Write-side front end of the 32x32 register file. Accepts write-backs from
//   the ALU and the LSU, queues them in acceptance order and drives the single
//   register-file write port at one write per cycle. Publishes a pending-write
//   mask for decode hazard checks and an optional bypass lookup.
//
//   Optional feature macro: REGFILE_WB_BYPASS_EN
//     defined     qry_hit/qry_data return the youngest pending value for
//                 qry_addr (queue entries win over the output stage)
//     undefined   qry_hit and qry_data are tied to 0
//
//   clk, rst_n                    clock, asynchronous active-low reset
//   alu_valid/alu_ready           ALU write-back handshake
//   alu_addr, alu_data            ALU destination register and value
//   lsu_valid/lsu_ready           LSU write-back handshake
//   lsu_addr, lsu_data            LSU destination register and value
//   rf_writeenable                register file write strobe
//   rf_writeadd, rf_writedata     register file write address and data
//   busy_mask                     bit i set while a write to ri is pending
//   count                         occupied queue entries
//   qry_addr                      bypass lookup address
//   qry_hit, qry_data             bypass lookup result
// ---------------------------------------------------------------------------
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [AW-1:0]    alu_addr,
  input  logic [DW-1:0]    alu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [AW-1:0]    lsu_addr,
  input  logic [DW-1:0]    lsu_data,
  output logic             rf_writeenable,
  output logic [AW-1:0]    rf_writeadd,
  output logic [DW-1:0]    rf_writedata,
  output logic [NREGS-1:0] busy_mask,
  output logic [CW-1:0]    count,
  input  logic [AW-1:0]    qry_addr,
  output logic             qry_hit,
  output logic [DW-1:0]    qry_data
);

  localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_SLOT   = CW'(DEPTH - 1);
  localparam logic [CW-1:0] TWO_FREE_LE = CW'(DEPTH - 2);

  logic                  alu_push, lsu_push;
  logic [DEPTH-1:0]      view_valid;
  wb_entry_t [DEPTH-1:0] view_entry;
  wb_entry_t             alu_entry, lsu_entry;
  logic                  head_valid;

  logic                  rf_we_q;
  logic [AW-1:0]         rf_addr_q;
  logic [DW-1:0]         rf_data_q;

  // Readiness looks only at the registered count: a pop in the same cycle
  // earns no credit. The LSU owns the last free slot.
  assign lsu_ready = rst_n && (count < FULL_CNT);
  assign alu_ready = rst_n && ((count <= TWO_FREE_LE) ||
                               ((count == LAST_SLOT) && !lsu_valid));

  // Writes to r0 complete the handshake but never enter the queue.
  assign lsu_push = lsu_valid && lsu_ready && is_real_write(lsu_addr);
  assign alu_push = alu_valid && alu_ready && is_real_write(alu_addr);

  assign lsu_entry = '{addr: lsu_addr, data: lsu_data};
  assign alu_entry = '{addr: alu_addr, data: alu_data};

  assign head_valid = view_valid[0];

  // The LSU takes push port 0 so it is older than a same-cycle ALU write.
  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push0_valid_i (lsu_push),
    .push0_entry_i (lsu_entry),
    .push1_valid_i (alu_push),
    .push1_entry_i (alu_entry),
    .pop_i         (head_valid),
    .count_o       (count),
    .view_valid_o  (view_valid),
    .view_entry_o  (view_entry)
  );

  // Output stage: one pop per cycle whenever the queue is non-empty. Address
  // and data hold their last values while the queue is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      rf_we_q <= head_valid;
      if (head_valid) begin
        rf_addr_q <= view_entry[0].addr;
        rf_data_q <= view_entry[0].data;
      end
    end
  end

  assign rf_writeenable = rf_we_q;
  assign rf_writeadd    = rf_addr_q;
  assign rf_writedata   = rf_data_q;

  always_comb begin
    busy_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (view_valid[k]) begin
        busy_mask[view_entry[k].addr] = 1'b1;
      end
    end
    if (rf_we_q) begin
      busy_mask[rf_addr_q] = 1'b1;
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  // Scan oldest to youngest so the youngest match is the one left standing;
  // the output stage is older than every queued entry.
  always_comb begin
    qry_hit  = 1'b0;
    qry_data = '0;
    if (is_real_write(qry_addr)) begin
      if (rf_we_q && (rf_addr_q == qry_addr)) begin
        qry_hit  = 1'b1;
        qry_data = rf_data_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (view_valid[k] && (view_entry[k].addr == qry_addr)) begin
          qry_hit  = 1'b1;
          qry_data = view_entry[k].data;
        end
      end
    end
  end
`else
  assign qry_hit  = 1'b0;
  assign qry_data = '0;

  // Queue data beyond the head and the query address are only consumed by
  // the bypass; fold them into a named sink so the build stays warning-free.
  wire unused_bypass = ^{qry_addr, view_entry};
`endif

endmodule : regfile_writeback
